// File: rtl/tick_mon_pkg.sv
// Shared constants for the tick monitor: register word addresses, the boot key
// and STATUS bit positions.
package tick_mon_pkg;

    localparam logic [7:0]  TM_REG_STATUS   = 8'h00;
    localparam logic [7:0]  TM_REG_BOOT     = 8'h01;
    localparam logic [7:0]  TM_REG_CAP_BASE = 8'h10;
    localparam logic [7:0]  TM_REG_CNT_BASE = 8'h20;

    localparam logic [15:0] TM_BOOT_KEY = 16'hB007;

    localparam int TM_STAT_PRESSED = 0;
    localparam int TM_STAT_CAP_VLD = 1;
    localparam int TM_STAT_NCH_LSB = 8;
    localparam int TM_STAT_SOF_LSB = 16;

endpackage

// File: rtl/tick_mon_debounce.sv
// Two-flop synchroniser followed by a debouncer: the stable level follows the raw
// input only after it has differed for 2^DEB_W consecutive cycles.
module tick_mon_debounce
#(
    parameter int DEB_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    logic             sync_a;
    logic             sync_b;
    logic [DEB_W-1:0] deb_cnt;

    // The button idles high, so the synchroniser and stable state reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            stable  <= 1'b1;
        end else if (sync_b == stable) begin
            deb_cnt <= '0;
        end else if (&deb_cnt) begin
            stable  <= sync_b;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

endmodule

// File: rtl/tick_mon_wb.sv
// Wishbone tick monitor: N_CH live tick counters captured on SOF, plus reset request.
// Define TICK_MON_BTN_EN to build in the button debounce and long-press reset path.
module tick_mon_wb
    import tick_mon_pkg::*;
#(
    parameter int          N_CH     = 2,
    parameter int          CNT_W    = 16,
    parameter int          DEB_W    = 16,
    parameter int unsigned LONG_CYC = 24'd12_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] tick_in,
    input  logic            tick_sof,
    input  logic            btn,
    output logic            rst_req,
    input  logic [7:0]      wb_addr,
    output logic [31:0]     wb_rdata,
    input  logic [31:0]     wb_wdata,
    input  logic            wb_we,
    input  logic            wb_cyc,
    output logic            wb_ack
);

    logic [CNT_W-1:0] cnt [N_CH];
    logic [CNT_W-1:0] cap [N_CH];
    logic [15:0]      sof_cnt;
    logic             cap_vld;
    logic             pressed;
    logic             long_hit;
    logic             wr_fire;
    logic [31:0]      rd_mux;

    assign wr_fire = wb_cyc & wb_we & wb_ack;

    // A tick coincident with SOF is included in the captured value.
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cap_q;
        logic [CNT_W-1:0] cnt_inc;

        assign cnt_inc = cnt_q + CNT_W'(tick_in[g]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                cap_q <= '0;
            end else begin
                cnt_q <= cnt_inc;
                if (tick_sof) begin
                    cap_q <= cnt_inc;
                end
            end
        end

        assign cnt[g] = cnt_q;
        assign cap[g] = cap_q;
    end

    // A capture in the same cycle as a firmware clear keeps cap_vld set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sof_cnt <= '0;
            cap_vld <= 1'b0;
        end else if (tick_sof) begin
            sof_cnt <= sof_cnt + 16'd1;
            cap_vld <= 1'b1;
        end else if (wr_fire && wb_addr == TM_REG_STATUS && wb_wdata[TM_STAT_CAP_VLD]) begin
            cap_vld <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (wb_addr == TM_REG_STATUS) begin
            rd_mux[TM_STAT_PRESSED]        = pressed;
            rd_mux[TM_STAT_CAP_VLD]        = cap_vld;
            rd_mux[TM_STAT_NCH_LSB +: 8]   = 8'(N_CH);
            rd_mux[TM_STAT_SOF_LSB +: 16]  = sof_cnt;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (wb_addr == TM_REG_CAP_BASE + 8'(i)) begin
                rd_mux = 32'(cap[i]);
            end
            if (wb_addr == TM_REG_CNT_BASE + 8'(i)) begin
                rd_mux = 32'(cnt[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_rdata <= '0;
        end else begin
            wb_ack   <= wb_cyc & ~wb_ack;
            wb_rdata <= (wb_cyc & ~wb_ack) ? rd_mux : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_req <= 1'b0;
        end else if (long_hit ||
                     (wr_fire && wb_addr == TM_REG_BOOT && wb_wdata[31:16] == TM_BOOT_KEY)) begin
            rst_req <= 1'b1;
        end
    end

`ifdef TICK_MON_BTN_EN
    localparam int               HOLD_W   = $clog2(LONG_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYC - 1);

    logic              btn_stable;
    logic [HOLD_W-1:0] hold_cnt;
    logic              unused_in;

    tick_mon_debounce #(
        .DEB_W (DEB_W)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (btn),
        .stable (btn_stable)
    );

    assign pressed   = ~btn_stable;
    assign long_hit  = pressed && (hold_cnt >= HOLD_PRE);
    assign unused_in = ^{wb_wdata[15:2], wb_wdata[0]};

    // Hold counter saturates so a very long press cannot wrap back below the threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (!pressed) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end
`else
    logic unused_in;

    assign pressed   = 1'b0;
    assign long_hit  = 1'b0;
    assign unused_in = ^{btn, wb_wdata[15:2], wb_wdata[0]};
`endif

endmodule

// File: tb/tb_tick_mon_wb.sv
// Self-checking bench for tick_mon_wb: a cycle-level reference model compared every
// cycle, plus directed register reads with hand-computed values.
module tb_tick_mon_wb;

    localparam int N_CH       = 2;
    localparam int CNT_W      = 8;
    localparam int DEB_W      = 4;
    localparam int LONG_CYC   = 100;
    localparam int DEB_SETTLE = 2 + (1 << DEB_W);

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b1;
    logic [N_CH-1:0] tick_in  = '0;
    logic            tick_sof = 1'b0;
    logic            btn      = 1'b1;
    logic            rst_req;
    logic [7:0]      wb_addr  = '0;
    logic [31:0]     wb_rdata;
    logic [31:0]     wb_wdata = '0;
    logic            wb_we    = 1'b0;
    logic            wb_cyc   = 1'b0;
    logic            wb_ack;

    int tests_run    = 0;
    int tests_failed = 0;
    bit chk_en       = 1'b0;

    always #5 clk = ~clk;

    tick_mon_wb #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .DEB_W    (DEB_W),
        .LONG_CYC (LONG_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_in  (tick_in),
        .tick_sof (tick_sof),
        .btn      (btn),
        .rst_req  (rst_req),
        .wb_addr  (wb_addr),
        .wb_rdata (wb_rdata),
        .wb_wdata (wb_wdata),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack)
    );

    // Reference model state: plain integers and a sample history of the button.
    int          m_cnt [N_CH];
    int          m_cap [N_CH];
    int          m_sof;
    bit          m_vld;
    bit          m_ack;
    bit          m_rst_req;
    bit          m_deb_level;
    int          m_hold;
    logic [31:0] m_rdata;
    bit          m_hist [$];

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int idx;
        m_read = 32'h0;
        idx    = int'(a);
        if (idx == 0) begin
            m_read = {m_sof[15:0], 8'(N_CH), 6'd0, m_vld, ~m_deb_level};
        end else if (idx >= 16 && idx < 16 + N_CH) begin
            m_read = 32'(m_cap[idx - 16]);
        end else if (idx >= 32 && idx < 32 + N_CH) begin
            m_read = 32'(m_cnt[idx - 32]);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_cnt[i] = 0;
            m_cap[i] = 0;
        end
        m_sof       = 0;
        m_vld       = 1'b0;
        m_ack       = 1'b0;
        m_rst_req   = 1'b0;
        m_rdata     = 32'h0;
        m_deb_level = 1'b1;
        m_hold      = 0;
        m_hist.delete();
        for (int k = 0; k < DEB_SETTLE - 1; k++) m_hist.push_back(1'b1);
    endfunction

    function automatic void model_step();
        logic [31:0] rd;
        bit          wr;
        rd = (wb_cyc && !m_ack) ? m_read(wb_addr) : 32'h0;
        wr = wb_cyc && wb_we && m_ack;
`ifdef TICK_MON_BTN_EN
        begin
            bit was_pressed;
            bit all_diff;
            was_pressed = ~m_deb_level;
            // The level two samples back must have differed for 2^DEB_W samples in a row.
            m_hist.push_back(btn);
            all_diff = 1'b1;
            for (int k = 0; k < (1 << DEB_W); k++) begin
                if (m_hist[k] == m_deb_level) all_diff = 1'b0;
            end
            if (all_diff) m_deb_level = ~m_deb_level;
            void'(m_hist.pop_front());
            if (was_pressed) m_hold++;
            else m_hold = 0;
            if (m_hold >= LONG_CYC) m_rst_req = 1'b1;
        end
`endif
        if (wr && wb_addr == 8'h01 && wb_wdata[31:16] == 16'hB007) m_rst_req = 1'b1;
        if (wr && wb_addr == 8'h00 && wb_wdata[1]) m_vld = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            m_cnt[i] = (m_cnt[i] + int'(tick_in[i])) % (1 << CNT_W);
        end
        if (tick_sof) begin
            for (int i = 0; i < N_CH; i++) m_cap[i] = m_cnt[i];
            m_sof = (m_sof + 1) % 65536;
            m_vld = 1'b1;
        end
        m_ack   = wb_cyc && !m_ack;
        m_rdata = rd;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_output("cyc_ack", 32'(wb_ack), 32'(m_ack));
            check_output("cyc_rdata", wb_rdata, m_rdata);
            check_output("cyc_rst_req", 32'(rst_req), 32'(m_rst_req));
        end
    end

    // One Wishbone access; cyc is held through the ack cycle so writes commit.
    task automatic apply_stimulus(input logic [7:0] addr, input bit we,
                                  input logic [31:0] wdata, input bit sof_on_ack,
                                  output logic [31:0] rdata);
        int waited;
        @(negedge clk);
        wb_addr  = addr;
        wb_we    = we;
        wb_wdata = wdata;
        wb_cyc   = 1'b1;
        waited   = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!wb_ack && waited < 4);
        check_output("ack_latency", 32'(waited), 32'd1);
        rdata    = wb_rdata;
        tick_sof = sof_on_ack;
        @(negedge clk);
        tick_sof = 1'b0;
        wb_cyc   = 1'b0;
        wb_we    = 1'b0;
    endtask

    task automatic read_check(input logic [7:0] addr, input logic [31:0] expected,
                              input string name);
        logic [31:0] rd;
        apply_stimulus(addr, 1'b0, 32'h0, 1'b0, rd);
        check_output(name, rd, expected);
    endtask

    task automatic wb_write(input logic [7:0] addr, input logic [31:0] data, input bit sof);
        logic [31:0] rd;
        apply_stimulus(addr, 1'b1, data, sof, rd);
    endtask

    task automatic pulse_ticks(input logic [N_CH-1:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick_in = mask;
            @(negedge clk);
            tick_in = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_ack", 32'(wb_ack), 32'd0);
        check_output("rst_rdata", wb_rdata, 32'd0);
        check_output("rst_rst_req", 32'(rst_req), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int acks;
        int edges;

        do_reset();
        chk_en = 1'b1;
        read_check(8'h00, 32'h0000_0200, "status_reset");

        // 5 ticks on ch0, 3 on ch1, then one SOF
        pulse_ticks(2'b11, 3);
        pulse_ticks(2'b01, 2);
        @(negedge clk) tick_sof = 1'b1;
        @(negedge clk) tick_sof = 1'b0;
        read_check(8'h10, 32'd5, "cap0");
        read_check(8'h11, 32'd3, "cap1");
        read_check(8'h00, 32'h0001_0202, "status_cap");

        // tick coincident with SOF, then clear and clear-vs-capture
        do_reset();
        pulse_ticks(2'b01, 4);
        @(negedge clk);
        tick_in  = 2'b01;
        tick_sof = 1'b1;
        @(negedge clk);
        tick_in  = '0;
        tick_sof = 1'b0;
        read_check(8'h10, 32'd5, "cap0_coinc");
        read_check(8'h20, 32'd5, "cnt0_coinc");
        read_check(8'h00, 32'h0001_0202, "status_coinc");
        wb_write(8'h00, 32'h0000_0002, 1'b0);
        read_check(8'h00, 32'h0001_0200, "status_clr");
        wb_write(8'h00, 32'h0000_0002, 1'b1);
        read_check(8'h00, 32'h0002_0202, "status_clr_vs_sof");

        // counter wrap at 2^CNT_W
        do_reset();
        pulse_ticks(2'b01, 257);
        read_check(8'h20, 32'd1, "cnt0_wrap");
        read_check(8'h21, 32'd0, "cnt1_idle");

        // unmapped and out-of-range channel addresses
        read_check(8'h15, 32'd0, "unmapped_15");
        read_check(8'h12, 32'd0, "cap_oor");
        read_check(8'h22, 32'd0, "cnt_oor");
        read_check(8'h01, 32'd0, "boot_read");
        read_check(8'hFF, 32'd0, "unmapped_ff");

        // cyc held for 6 cycles yields alternating acks
        @(negedge clk);
        wb_addr = 8'h00;
        wb_we   = 1'b0;
        wb_cyc  = 1'b1;
        acks    = 0;
        repeat (6) begin
            @(negedge clk);
            if (wb_ack) acks++;
        end
        wb_cyc = 1'b0;
        check_output("b2b_acks", 32'(acks), 32'd3);

        // boot key
        wb_write(8'h01, 32'h1234_0000, 1'b0);
        check_output("boot_badkey", 32'(rst_req), 32'd0);
        wb_write(8'h02, 32'hB007_0000, 1'b0);
        check_output("boot_wrongaddr", 32'(rst_req), 32'd0);
        wb_write(8'h01, 32'hB007_0000, 1'b0);
        check_output("boot_key", 32'(rst_req), 32'd1);
        repeat (5) @(negedge clk);
        check_output("boot_sticky", 32'(rst_req), 32'd1);
        do_reset();

        // reset asserted while ack is high
        @(negedge clk);
        wb_addr = 8'h20;
        wb_cyc  = 1'b1;
        @(posedge clk);
        #1;
        check_output("midrst_ack", 32'(wb_ack), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("midrst_drop", 32'(wb_ack), 32'd0);
        @(negedge clk);
        wb_cyc = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

`ifdef TICK_MON_BTN_EN
        // short glitch is filtered
        do_reset();
        @(negedge clk) btn = 1'b0;
        repeat (10) @(negedge clk);
        btn = 1'b1;
        repeat (30) @(negedge clk);
        read_check(8'h00, 32'h0000_0200, "btn_glitch");

        // held press: debounced after 18 edges, rst_req 100 edges later
        do_reset();
        @(negedge clk) btn = 1'b0;
        repeat (16) @(negedge clk);
        read_check(8'h00, 32'h0000_0200, "btn_pre_debounce");
        read_check(8'h00, 32'h0000_0201, "btn_pressed");
        edges = 22;
        while (!rst_req && edges < 300) begin
            @(negedge clk);
            edges++;
        end
        check_output("long_press_edges", 32'(edges), 32'(DEB_SETTLE + LONG_CYC));
        btn = 1'b1;

        // release before the long-press threshold
        do_reset();
        @(negedge clk) btn = 1'b0;
        repeat (DEB_SETTLE + 50) @(negedge clk);
        btn = 1'b1;
        repeat (150) @(negedge clk);
        check_output("btn_release_no_req", 32'(rst_req), 32'd0);
        read_check(8'h00, 32'h0000_0200, "btn_released");
`else
        // button path absent: a long press has no effect
        do_reset();
        @(negedge clk) btn = 1'b0;
        repeat (200) @(negedge clk);
        read_check(8'h00, 32'h0000_0200, "btn_disabled");
        check_output("btn_disabled_req", 32'(rst_req), 32'd0);
        btn = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
